// File: rtl/icache_refill_responder_pkg.sv
// icache_refill_responder_pkg: shared widths and FSM state for the instruction refill responder
package icache_refill_responder_pkg;
  localparam int WORD_SIZE = 32;
  localparam int BLOCK_SIZE = 1024;
  localparam int ICACHE_LINES = 8;
  localparam int ICACHE_INDEX_BITS = 3;
  localparam int ICACHE_BEATS = BLOCK_SIZE / WORD_SIZE;
  localparam int CNT_BITS = $clog2(ICACHE_BEATS);
  localparam int WORD_BITS = $clog2(WORD_SIZE);
  localparam int BYTE_BITS = $clog2(WORD_SIZE / 8);
  localparam int OFFSET_BITS = $clog2(BLOCK_SIZE / 8);
  localparam int BASE_BITS = WORD_SIZE - OFFSET_BITS;
  localparam int TAG_BITS = BASE_BITS - ICACHE_INDEX_BITS;
  typedef enum logic {IDLE, FILL} state_t;
endpackage

// File: rtl/icache_line_array.sv
// icache_line_array: direct-mapped valid/tag/data storage with a combinational lookup port
module icache_line_array
  import icache_refill_responder_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ICACHE_INDEX_BITS-1:0] rd_index,
  input  logic [TAG_BITS-1:0]          rd_tag,
  output logic                         rd_hit,
  output logic [BLOCK_SIZE-1:0]        rd_data,
  input  logic                         we,
  input  logic [ICACHE_INDEX_BITS-1:0] wr_index,
  input  logic [TAG_BITS-1:0]          wr_tag,
  input  logic [BLOCK_SIZE-1:0]        wr_data
);
  logic [ICACHE_LINES-1:0] valid_q, valid_d;
  logic [TAG_BITS-1:0] tag_q [ICACHE_LINES];
  logic [BLOCK_SIZE-1:0] data_q [ICACHE_LINES];
  assign rd_hit = valid_q[rd_index] && (tag_q[rd_index] == rd_tag);
  assign rd_data = rd_hit ? data_q[rd_index] : '0;
  // a completed fill marks its line valid
  always_comb begin
    valid_d = valid_q;
    if (we) valid_d[wr_index] = 1'b1;
  end
  // valid bits clear on reset; tag and data are plain storage
  always_ff @(posedge clk) begin
    valid_q <= rst ? '0 : valid_d;
    if (we) begin
      tag_q[wr_index] <= wr_tag;
      data_q[wr_index] <= wr_data;
    end
  end
endmodule

// File: rtl/icache_refill_responder.sv
// icache_refill_responder: returns a 128-byte instruction block per PC, refilling misses beat by beat
module icache_refill_responder
  import icache_refill_responder_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WORD_SIZE-1:0]  in,
  output logic [BLOCK_SIZE-1:0] out,
  output logic                  hit,
  output logic                  mem_req,
  output logic [WORD_SIZE-1:0]  mem_addr,
  input  logic                  mem_valid,
  input  logic [WORD_SIZE-1:0]  mem_data
);
  state_t state_q, state_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic [BASE_BITS-1:0] base_q, base_d;
  logic [BLOCK_SIZE-1:0] buf_q, buf_d;
  logic mem_req_q, mem_req_d;
  logic [WORD_SIZE-1:0] mem_addr_q, mem_addr_d;
  logic we;
  logic [$clog2(BLOCK_SIZE)-1:0] beat_top;
  logic unused_offset;
  assign unused_offset = ^in[OFFSET_BITS-1:0];
  assign beat_top = {~cnt_q, {WORD_BITS{1'b1}}};
  assign mem_req = mem_req_q;
  assign mem_addr = mem_addr_q;
  icache_line_array u_lines (
    .clk     (clk),
    .rst     (rst),
    .rd_index(in[OFFSET_BITS +: ICACHE_INDEX_BITS]),
    .rd_tag  (in[WORD_SIZE-1 -: TAG_BITS]),
    .rd_hit  (hit),
    .rd_data (out),
    .we      (we),
    .wr_index(base_q[ICACHE_INDEX_BITS-1:0]),
    .wr_tag  (base_q[BASE_BITS-1 -: TAG_BITS]),
    .wr_data (buf_d)
  );
  // IDLE latches a missing block; FILL collects beats and commits the line on the last one
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    base_d = base_q;
    buf_d = buf_q;
    mem_req_d = mem_req_q;
    mem_addr_d = mem_addr_q;
    we = 1'b0;
    if (state_q == IDLE) begin
      if (!hit) begin
        state_d = FILL;
        base_d = in[WORD_SIZE-1:OFFSET_BITS];
        cnt_d = '0;
        mem_req_d = 1'b1;
        mem_addr_d = {in[WORD_SIZE-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
      end
    end else if (mem_valid) begin
      buf_d[beat_top -: WORD_SIZE] = mem_data;
      cnt_d = cnt_q + 1'b1;
      mem_addr_d = {base_q, cnt_d, {BYTE_BITS{1'b0}}};
      if (&cnt_q) begin
        we = 1'b1;
        state_d = IDLE;
        mem_req_d = 1'b0;
      end
    end
  end
  // FSM state and registered memory-side outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      mem_req_q <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      mem_req_q <= mem_req_d;
      mem_addr_q <= mem_addr_d;
    end
    base_q <= base_d;
    buf_q <= buf_d;
  end
endmodule

// File: tb/tb_icache_refill_responder.sv
// tb_icache_refill_responder: scoreboard bench for the instruction refill responder
module tb_icache_refill_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] in = '0;
  logic [1023:0] out;
  logic hit;
  logic mem_req;
  logic [31:0] mem_addr;
  logic mem_valid = 1'b0;
  logic [31:0] mem_data = '0;
  int n_chk = 0;
  int n_fail = 0;
  typedef struct {
    string name;
    logic hit;
    logic req;
    logic chk_addr;
    logic [31:0] addr;
    logic [31:0] hi;
    logic [31:0] lo;
  } st_t;
  st_t st_q[$];
  logic [31:0] beat_q[$];
  st_t s_cur;
  logic [31:0] a_cur;
  icache_refill_responder dut (
    .clk      (clk),
    .rst      (rst),
    .in       (in),
    .out      (out),
    .hit      (hit),
    .mem_req  (mem_req),
    .mem_addr (mem_addr),
    .mem_valid(mem_valid),
    .mem_data (mem_data)
  );
  always #5 clk = ~clk;
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  // monitor: every accepted beat must carry the next expected address; status snapshots are compared as queued
  always @(negedge clk) begin
    if (mem_req && mem_valid) begin
      n_chk++;
      if (beat_q.size() == 0) begin
        n_fail++;
        $display("FAIL beat_unexpected: mem_addr=%h with no beat expected", mem_addr);
      end else begin
        a_cur = beat_q.pop_front();
        if (mem_addr !== a_cur) begin
          n_fail++;
          $display("FAIL beat_addr: mem_addr=%h expected %h", mem_addr, a_cur);
        end
      end
    end
    while (st_q.size() != 0) begin
      s_cur = st_q.pop_front();
      n_chk++;
      if (hit !== s_cur.hit || mem_req !== s_cur.req || out[1023:992] !== s_cur.hi || out[31:0] !== s_cur.lo ||
          (s_cur.chk_addr && mem_addr !== s_cur.addr)) begin
        n_fail++;
        $display("FAIL %s: hit=%b req=%b addr=%h hi=%h lo=%h, expected hit=%b req=%b addr=%h(chk=%b) hi=%h lo=%h",
                 s_cur.name, hit, mem_req, mem_addr, out[1023:992], out[31:0],
                 s_cur.hit, s_cur.req, s_cur.addr, s_cur.chk_addr, s_cur.hi, s_cur.lo);
      end
    end
  end
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic expect_st(input string n, input logic h, input logic r, input logic ca, input logic [31:0] a,
                           input logic [31:0] hi, input logic [31:0] lo);
    st_t s;
    s.name = n;
    s.hit = h;
    s.req = r;
    s.chk_addr = ca;
    s.addr = a;
    s.hi = hi;
    s.lo = lo;
    st_q.push_back(s);
  endtask
  // memory side: presents beats k0..k1-1 of the block at base, optionally with an idle cycle before each
  task automatic fill(input logic [31:0] base, input logic [31:0] seed, input bit stall, input int k0, input int k1);
    for (int k = k0; k < k1; k++) begin
      if (stall) begin
        mem_valid = 1'b0;
        expect_st("stall_hold", 1'b0, 1'b1, 1'b1, base + 32'(4 * k), 32'h0, 32'h0);
        step();
      end
      mem_valid = 1'b1;
      mem_data = seed + 32'(k);
      beat_q.push_back(base + 32'(4 * k));
      step();
    end
    mem_valid = 1'b0;
  endtask
  initial begin
    step();
    step();
    expect_st("reset", 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0);
    step();
    rst = 1'b0;
    in = 32'h0000_0000;
    expect_st("miss_zero", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    step();
    expect_st("req_start", 1'b0, 1'b1, 1'b1, 32'h0, 32'h0, 32'h0);
    fill(32'h0, 32'h1000_0000, 1'b0, 0, 32);
    expect_st("cold_hit", 1'b1, 1'b0, 1'b0, 32'h0, 32'h1000_0000, 32'h1000_001F);
    step();
    in = 32'h0000_007C;
    expect_st("offset_ignored", 1'b1, 1'b0, 1'b0, 32'h0, 32'h1000_0000, 32'h1000_001F);
    step();
    mem_valid = 1'b1;
    mem_data = 32'hDEAD_BEEF;
    expect_st("idle_valid", 1'b1, 1'b0, 1'b0, 32'h0, 32'h1000_0000, 32'h1000_001F);
    step();
    mem_valid = 1'b0;
    expect_st("idle_valid_ignored", 1'b1, 1'b0, 1'b0, 32'h0, 32'h1000_0000, 32'h1000_001F);
    step();
    in = 32'h0000_0080;
    expect_st("stall_miss", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    step();
    fill(32'h80, 32'h1000_0000, 1'b1, 0, 32);
    expect_st("stall_hit", 1'b1, 1'b0, 1'b0, 32'h0, 32'h1000_0000, 32'h1000_001F);
    step();
    in = 32'h0000_0000;
    expect_st("idx0_kept", 1'b1, 1'b0, 1'b0, 32'h0, 32'h1000_0000, 32'h1000_001F);
    step();
    in = 32'h0000_0400;
    expect_st("conflict_miss", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    step();
    fill(32'h400, 32'h3000_0000, 1'b0, 0, 16);
    in = 32'h0000_0000;
    expect_st("conflict_old_kept", 1'b1, 1'b1, 1'b1, 32'h440, 32'h1000_0000, 32'h1000_001F);
    step();
    in = 32'h0000_0400;
    fill(32'h400, 32'h3000_0000, 1'b0, 16, 32);
    expect_st("conflict_new", 1'b1, 1'b0, 1'b0, 32'h0, 32'h3000_0000, 32'h3000_001F);
    step();
    in = 32'h0000_0000;
    expect_st("return_miss", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    step();
    expect_st("refill_start", 1'b0, 1'b1, 1'b1, 32'h0, 32'h0, 32'h0);
    fill(32'h0, 32'h5000_0000, 1'b0, 0, 32);
    expect_st("refill_hit", 1'b1, 1'b0, 1'b0, 32'h0, 32'h5000_0000, 32'h5000_001F);
    step();
    in = 32'h0000_0100;
    expect_st("hum_miss", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    step();
    fill(32'h100, 32'h4000_0000, 1'b0, 0, 5);
    in = 32'h0000_0080;
    expect_st("hum_hit", 1'b1, 1'b1, 1'b1, 32'h114, 32'h1000_0000, 32'h1000_001F);
    step();
    fill(32'h100, 32'h4000_0000, 1'b0, 5, 10);
    rst = 1'b1;
    step();
    rst = 1'b0;
    expect_st("rst_mid_fill", 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0);
    step();
    expect_st("post_rst_req", 1'b0, 1'b1, 1'b1, 32'h80, 32'h0, 32'h0);
    step();
    step();
    n_chk++;
    if (beat_q.size() != 0 || st_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: beats left=%0d status left=%0d, expected 0 and 0", beat_q.size(), st_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/icache_refill_responder.md
Name: icache_refill_responder

Overview:
- Instruction-side responder to the fetch unit.
- Accepts a fetch PC and returns a whole 128-byte instruction block plus a hit flag.
- Direct-mapped block store; misses are refilled from main memory as 32-bit beats under a request/valid handshake.
- Sits between the fetch/issue stage and the unified memory model; fetch polls `hit` each posedge and walks `out` from bit 1023 downward.

Parameters:
- WORD_SIZE, 32, instruction/beat width in bits.
- BLOCK_SIZE, 1024, block width in bits (32 words, 128 bytes).
- LINES, 8, number of direct-mapped lines (power of two).
- INDEX_BITS, 3, log2(LINES).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- in  in  WORD_SIZE  fetch byte address (PC); block base = in[31:7].
- out  out  BLOCK_SIZE  block data; word at base+4k occupies bits [1023-32k : 992-32k].
- hit  out  1  requested block resident and `out` valid.
- mem_req  out  1  refill request active.
- mem_addr  out  WORD_SIZE  byte address of the beat currently requested.
- mem_valid  in  1  memory presents a beat this cycle.
- mem_data  in  WORD_SIZE  beat data.

Behaviour:
- Address split:
  - offset = in[6:0], ignored for lookup.
  - index = in[7+INDEX_BITS-1:7].
  - tag = in[31:7+INDEX_BITS].
- Lookup is combinational: hit = valid[index] && tag_array[index]==tag.
  - On hit, out = data_array[index].
  - On miss, out = all zeros.
  - hit is never X; it is 0 out of reset.
- States:
  - IDLE:
    - If !hit, latch fill_base = {in[31:7],7'b0} and fill_index.
    - Clear beat counter cnt (5 bits); go to FILL.
    - mem_req=1 and mem_addr=fill_base are registered, visible the next cycle.
  - FILL:
    - mem_req=1; mem_addr = fill_base + 4*cnt.
    - On each cycle with mem_valid=1: write mem_data into fill buffer bits [1023-32*cnt : 992-32*cnt], then cnt++.
    - mem_valid=0 stalls with no change.
    - On the beat with cnt==31: write the fill buffer (including that beat) to data_array[fill_index], write tag, set valid, drop mem_req, return to IDLE.
- Latency: with mem_valid held high, hit rises in the cycle after the 33rd posedge following presentation of a missing `in`.
- A hit costs 0 cycles (combinational).
- Hit-under-miss:
  - During FILL, lookup of the current `in` continues against the unchanged array.
  - A different resident block reports hit=1.
  - The fill's own index is not marked valid until completion.
- If `in` changes mid-fill, the fill completes for the latched block (no abort). IDLE then re-evaluates the new `in`.
- Conflicting tag at the same index: the old line is overwritten only at fill completion.
- mem_valid while in IDLE is ignored.
- Reset (including mid-fill), effective at the next posedge:
  - All valid bits cleared; state=IDLE; cnt=0; mem_req=0; mem_addr=0.
  - A partial fill is discarded.
  - Data and tag arrays need not be cleared.

Decomposition:
- define.v holds WORD_SIZE and BLOCK_SIZE (already shared), plus new ICACHE_LINES, ICACHE_INDEX_BITS and ICACHE_BEATS (=BLOCK_SIZE/WORD_SIZE).
- Sub-module icache_line_array owns the storage:
  - valid/tag/data arrays, combinational read port, single write port (index, tag, data, we), and synchronous valid clear on rst.
  - The FSM and fill buffer stay in icache_refill_responder.

Test Plan:
- Reset, then in=0: hit=0, out=0. Next cycle mem_req=1, mem_addr=0.
- Cold fill from in=0, memory returning beat k = 0x1000_0000+k with continuous mem_valid:
  - mem_addr steps 0,4,…,124.
  - hit=1 after the 33rd posedge.
  - out[1023:992]=0x10000000; out[31:0]=0x1000001F.
- Stalled fill: mem_valid toggles 1,0,1,0: cnt advances only on valid cycles, mem_addr holds during stalls, and the final data is identical to the continuous case.
- Conflict, with LINES=8: fill 0x0000, then in=0x0400 (same index, new tag):
  - hit=0 and a refill completes.
  - Returning to in=0x0000 misses again.
- Hit-under-miss and reset:
  - With 0x0080 resident, start a miss on 0x0100, then switch in to 0x0080 mid-fill: hit=1 immediately.
  - Assert rst at beat 10: next cycle mem_req=0, and in=0x0080 reports hit=0.
